// File: rtl/bresenham_ray_walker.sv
// Sequential Bresenham line walker: accepts one segment, folds it into a single
// octant, then streams every cell from (x0,y0) to (x1,y1) over valid/ready.
module bresenham_ray_walker #(
   parameter int X_W = 5,
   parameter int Y_W = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [X_W-1:0] in_x0,
   input  logic [X_W-1:0] in_x1,
   input  logic [Y_W-1:0] in_y0,
   input  logic [Y_W-1:0] in_y1,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [X_W-1:0] out_x,
   output logic [Y_W-1:0] out_y,
   output logic           out_last,
   output logic           busy
);

   localparam int MW = (X_W > Y_W) ? X_W : Y_W;
   localparam int W  = MW + 1;
   localparam int EW = MW + 3;

   typedef enum logic [1:0] {IDLE, SETUP, WALK} state_t;

   state_t         state_reg, state_next;
   logic [X_W-1:0] x0_reg, x0_next, x1_reg, x1_next;
   logic [Y_W-1:0] y0_reg, y0_next, y1_reg, y1_next;
   logic [X_W-1:0] cur_x_reg, cur_x_next;
   logic [Y_W-1:0] cur_y_reg, cur_y_next;
   logic [EW-1:0]  err_reg, err_next;
   logic [EW-1:0]  inc_reg, inc_next;
   logic [EW-1:0]  dec_reg, dec_next;
   logic [W-1:0]   rem_reg, rem_next;
   logic           steep_reg, steep_next;
   logic           sx_neg_reg, sx_neg_next;
   logic           sy_neg_reg, sy_neg_next;

   // Octant normalisation, evaluated from the latched endpoints during SETUP.
   logic signed [W-1:0] dx_diff, dy_diff;
   logic [W-1:0]        dx_abs, dy_abs, d_maj, d_min;
   logic [EW-1:0]       d_maj_e, d_min_e;
   logic                steep;

   always_comb begin
      dx_diff = $signed({{(W-X_W){1'b0}}, x1_reg}) - $signed({{(W-X_W){1'b0}}, x0_reg});
      dy_diff = $signed({{(W-Y_W){1'b0}}, y1_reg}) - $signed({{(W-Y_W){1'b0}}, y0_reg});
      dx_abs  = dx_diff[W-1] ? -dx_diff : dx_diff;
      dy_abs  = dy_diff[W-1] ? -dy_diff : dy_diff;
      steep   = dy_abs > dx_abs;
      d_maj   = steep ? dy_abs : dx_abs;
      d_min   = steep ? dx_abs : dy_abs;
      d_maj_e = {2'b00, d_maj};
      d_min_e = {2'b00, d_min};
   end

   logic err_pos, step_x, step_y;

   always_comb begin
      err_pos = !err_reg[EW-1] && (err_reg != '0);
      step_x  = steep_reg ? err_pos : 1'b1;
      step_y  = steep_reg ? 1'b1 : err_pos;
   end

   always_comb begin
      state_next  = state_reg;
      x0_next     = x0_reg;
      x1_next     = x1_reg;
      y0_next     = y0_reg;
      y1_next     = y1_reg;
      cur_x_next  = cur_x_reg;
      cur_y_next  = cur_y_reg;
      err_next    = err_reg;
      inc_next    = inc_reg;
      dec_next    = dec_reg;
      rem_next    = rem_reg;
      steep_next  = steep_reg;
      sx_neg_next = sx_neg_reg;
      sy_neg_next = sy_neg_reg;
      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               x0_next    = in_x0;
               x1_next    = in_x1;
               y0_next    = in_y0;
               y1_next    = in_y1;
               state_next = SETUP;
            end
         end
         SETUP: begin
            steep_next  = steep;
            sx_neg_next = dx_diff[W-1];
            sy_neg_next = dy_diff[W-1];
            err_next    = (d_min_e << 1) - d_maj_e;
            inc_next    = d_min_e << 1;
            dec_next    = (d_min_e - d_maj_e) << 1;
            rem_next    = d_maj;
            cur_x_next  = x0_reg;
            cur_y_next  = y0_reg;
            state_next  = WALK;
         end
         WALK: begin
            if (out_ready) begin
               if (rem_reg == '0) begin
                  state_next = IDLE;
               end else begin
                  if (step_x)
                     cur_x_next = sx_neg_reg ? cur_x_reg - X_W'(1) : cur_x_reg + X_W'(1);
                  if (step_y)
                     cur_y_next = sy_neg_reg ? cur_y_reg - Y_W'(1) : cur_y_reg + Y_W'(1);
                  err_next = err_pos ? err_reg + dec_reg : err_reg + inc_reg;
                  rem_next = rem_reg - W'(1);
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         x0_reg     <= '0;
         x1_reg     <= '0;
         y0_reg     <= '0;
         y1_reg     <= '0;
         cur_x_reg  <= '0;
         cur_y_reg  <= '0;
         err_reg    <= '0;
         inc_reg    <= '0;
         dec_reg    <= '0;
         rem_reg    <= '0;
         steep_reg  <= 1'b0;
         sx_neg_reg <= 1'b0;
         sy_neg_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         x0_reg     <= x0_next;
         x1_reg     <= x1_next;
         y0_reg     <= y0_next;
         y1_reg     <= y1_next;
         cur_x_reg  <= cur_x_next;
         cur_y_reg  <= cur_y_next;
         err_reg    <= err_next;
         inc_reg    <= inc_next;
         dec_reg    <= dec_next;
         rem_reg    <= rem_next;
         steep_reg  <= steep_next;
         sx_neg_reg <= sx_neg_next;
         sy_neg_reg <= sy_neg_next;
      end
   end

   // All outputs come straight from registers or state decode.
   assign in_ready  = (state_reg == IDLE);
   assign busy      = (state_reg != IDLE);
   assign out_valid = (state_reg == WALK);
   assign out_last  = (state_reg == WALK) && (rem_reg == '0);
   assign out_x     = cur_x_reg;
   assign out_y     = cur_y_reg;

endmodule

// File: tb/tb_bresenham_ray_walker.sv
// Directed bench for bresenham_ray_walker: table of segments with hand-derived
// cell lists, plus backpressure, reset-mid-walk and wide-parameter sequences.
module tb_bresenham_ray_walker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       in_valid, in_ready, out_valid, out_ready, out_last, busy;
   logic [4:0] in_x0, in_x1, out_x;
   logic [3:0] in_y0, in_y1, out_y;

   logic       w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_out_last, w_busy;
   logic [7:0] w_in_x0, w_in_x1, w_out_x;
   logic [5:0] w_in_y0, w_in_y1, w_out_y;

   bresenham_ray_walker #(.X_W(5), .Y_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_x0(in_x0), .in_x1(in_x1), .in_y0(in_y0), .in_y1(in_y1),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_x(out_x), .out_y(out_y), .out_last(out_last), .busy(busy)
   );

   bresenham_ray_walker #(.X_W(8), .Y_W(6)) dut_w (
      .clk(clk), .rst_n(rst_n),
      .in_valid(w_in_valid), .in_ready(w_in_ready),
      .in_x0(w_in_x0), .in_x1(w_in_x1), .in_y0(w_in_y0), .in_y1(w_in_y1),
      .out_valid(w_out_valid), .out_ready(w_out_ready),
      .out_x(w_out_x), .out_y(w_out_y), .out_last(w_out_last), .busy(w_busy)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   typedef struct {
      int               x0, y0, x1, y1, n;
      logic [0:7][7:0]  ex;
      logic [0:7][7:0]  ey;
   } vec_t;

   vec_t vecs[8];

   function automatic vec_t mk(input int x0, input int y0, input int x1, input int y1,
                               input int n, input logic [63:0] xs, input logic [63:0] ys);
      vec_t v;
      v.x0 = x0; v.y0 = y0; v.x1 = x1; v.y1 = y1; v.n = n;
      v.ex = xs;
      v.ey = ys;
      return v;
   endfunction

   task automatic accept(input vec_t v, input bit hold);
      @(negedge clk);
      in_x0    = 5'(v.x0);
      in_y0    = 4'(v.y0);
      in_x1    = 5'(v.x1);
      in_y1    = 4'(v.y1);
      in_valid = 1'b1;
      chk("in_ready_at_accept", int'(in_ready), 1);
      @(posedge clk);
      #1;
      if (!hold) in_valid = 1'b0;
   endtask

   // Starts on the negedge right after the accepting edge (SETUP cycle).
   task automatic walk(input vec_t v, input bit toggle, input string tag);
      int k       = 0;
      bit done    = 1'b0;
      bit stalled = 1'b0;
      int px      = 0;
      int py      = 0;
      int first   = -1;
      for (int cyc = 0; cyc < 64 && !done; cyc++) begin
         @(negedge clk);
         out_ready = toggle ? cyc[0] : 1'b1;
         chk({tag, "_in_ready_low"}, int'(in_ready), 0);
         chk({tag, "_busy_high"}, int'(busy), 1);
         if (out_valid) begin
            if (first < 0) begin
               first = cyc;
               chk({tag, "_first_valid_latency"}, cyc, 1);
            end
            if (stalled) begin
               chk({tag, "_stall_x_stable"}, int'(out_x), px);
               chk({tag, "_stall_y_stable"}, int'(out_y), py);
            end
            if (out_ready) begin
               if (k < v.n) begin
                  chk({tag, "_cell_x"}, int'(out_x), int'(v.ex[k]));
                  chk({tag, "_cell_y"}, int'(out_y), int'(v.ey[k]));
                  chk({tag, "_cell_last"}, int'(out_last), int'(k == v.n - 1));
               end else begin
                  chk({tag, "_extra_cell"}, k, v.n - 1);
               end
               k++;
               if (out_last) done = 1'b1;
            end
            px = int'(out_x);
            py = int'(out_y);
         end
         stalled = out_valid && !out_ready;
      end
      chk({tag, "_cell_count"}, k, v.n);
      $display("seg (%0d,%0d)->(%0d,%0d) %s: %0d cells", v.x0, v.y0, v.x1, v.y1, tag, k);
      @(negedge clk);
      out_ready = 1'b1;
      chk({tag, "_idle_in_ready"}, int'(in_ready), 1);
      chk({tag, "_idle_busy"}, int'(busy), 0);
      chk({tag, "_idle_out_valid"}, int'(out_valid), 0);
   endtask

   initial begin
      int rx[3];
      int ry[3];
      int k;
      int px;
      int py;

      vecs[0] = mk(0, 0, 4, 2, 5,   {8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 24'd0},
                                    {8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 24'd0});
      vecs[1] = mk(3, 7, 1, 1, 7,   {8'd3, 8'd3, 8'd2, 8'd2, 8'd2, 8'd1, 8'd1, 8'd0},
                                    {8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0});
      vecs[2] = mk(5, 5, 5, 5, 1,   {8'd5, 56'd0}, {8'd5, 56'd0});
      vecs[3] = mk(10, 2, 3, 2, 8,  {8'd10, 8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3},
                                    {8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2});
      vecs[4] = mk(0, 15, 3, 12, 4, {8'd0, 8'd1, 8'd2, 8'd3, 32'd0},
                                    {8'd15, 8'd14, 8'd13, 8'd12, 32'd0});
      vecs[5] = mk(0, 0, 2, 1, 3,   {8'd0, 8'd1, 8'd2, 40'd0}, {8'd0, 8'd0, 8'd1, 40'd0});
      vecs[6] = mk(2, 2, 0, 2, 3,   {8'd2, 8'd1, 8'd0, 40'd0}, {8'd2, 8'd2, 8'd2, 40'd0});
      vecs[7] = mk(1, 1, 1, 3, 3,   {8'd1, 8'd1, 8'd1, 40'd0}, {8'd1, 8'd2, 8'd3, 40'd0});

      rst_n = 1'b0;
      in_valid = 1'b0; out_ready = 1'b1;
      in_x0 = '0; in_x1 = '0; in_y0 = '0; in_y1 = '0;
      w_in_valid = 1'b0; w_out_ready = 1'b1;
      w_in_x0 = '0; w_in_x1 = '0; w_in_y0 = '0; w_in_y1 = '0;

      #12;
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_last", int'(out_last), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_out_x", int'(out_x), 0);
      chk("rst_out_y", int'(out_y), 0);
      chk("rst_w_in_ready", int'(w_in_ready), 1);
      chk("rst_w_busy", int'(w_busy), 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 5; i++) begin
         accept(vecs[i], 1'b0);
         walk(vecs[i], 1'b0, $sformatf("vec%0d", i));
      end

      // Backpressure, with the next request held on in_valid throughout the walk.
      accept(vecs[5], 1'b1);
      in_x0 = 5'(vecs[6].x0); in_y0 = 4'(vecs[6].y0);
      in_x1 = 5'(vecs[6].x1); in_y1 = 4'(vecs[6].y1);
      walk(vecs[5], 1'b1, "bp");
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      walk(vecs[6], 1'b0, "bp_held");

      // Reset asserted while the 3rd cell of (0,0)->(9,4) is on the output.
      rx = '{0, 1, 2};
      ry = '{0, 0, 1};
      @(negedge clk);
      in_x0 = 5'd0; in_y0 = 4'd0; in_x1 = 5'd9; in_y1 = 4'd4; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      k = 0;
      for (int cyc = 0; cyc < 10 && k < 3; cyc++) begin
         @(negedge clk);
         if (out_valid) begin
            chk("rstwalk_cell_x", int'(out_x), rx[k]);
            chk("rstwalk_cell_y", int'(out_y), ry[k]);
            k++;
         end
      end
      chk("rstwalk_reached_3rd", k, 3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", int'(out_valid), 0);
      chk("async_rst_in_ready", int'(in_ready), 1);
      chk("async_rst_busy", int'(busy), 0);
      chk("async_rst_out_last", int'(out_last), 0);
      $display("reset asserted mid-walk after %0d cells", k);
      @(negedge clk);
      rst_n = 1'b1;
      accept(vecs[7], 1'b0);
      walk(vecs[7], 1'b0, "post_rst");

      // Wide instance, full-range extremes.
      @(negedge clk);
      w_in_x0 = 8'd255; w_in_y0 = 6'd0; w_in_x1 = 8'd0; w_in_y1 = 6'd63; w_in_valid = 1'b1;
      @(posedge clk);
      #1;
      w_in_valid = 1'b0;
      k = 0; px = 0; py = 0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         @(negedge clk);
         if (w_out_valid) begin
            if (k == 0) begin
               chk("wide_first_x", int'(w_out_x), 255);
               chk("wide_first_y", int'(w_out_y), 0);
            end else begin
               chk("wide_step_dx", px - int'(w_out_x), 1);
               chk("wide_step_dy", int'((int'(w_out_y) - py == 0) || (int'(w_out_y) - py == 1)), 1);
            end
            chk("wide_last", int'(w_out_last), int'(k == 255));
            px = int'(w_out_x);
            py = int'(w_out_y);
            k++;
            if (w_out_last) break;
         end
      end
      chk("wide_cell_count", k, 256);
      chk("wide_end_x", px, 0);
      chk("wide_end_y", py, 63);
      $display("seg (255,0)->(0,63) wide: %0d cells", k);
      @(negedge clk);
      chk("wide_idle_in_ready", int'(w_in_ready), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
